// File: rtl/cache_pkg.sv
// Shared cache/memory-side types: address and line widths, MESI state and the
// main-memory arbiter state encoding.
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DEF_LINE_W = 66;

    typedef logic [ADDR_W-1:0] Taddress;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } Tmesi_state;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } Tarb_state;

endpackage

// File: rtl/mm_access_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping
// modulo NUM_REQ. Purely combinational.
module mm_access_arbiter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               valid
);

    // Scan from the pointer upward; the first hit locks out later candidates.
    always_comb begin
        int               sum_v;
        logic [PTR_W-1:0] idx_v;
        logic             hit_v;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        sum_v      = 0;
        idx_v      = '0;
        hit_v      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v          = int'(ptr) + k;
            sum_v          = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
            idx_v          = PTR_W'(sum_v);
            hit_v          = !valid && req[idx_v];
            winner[idx_v]  = winner[idx_v] | hit_v;
            winner_idx     = hit_v ? idx_v : winner_idx;
            valid          = valid | hit_v;
        end
    end

endmodule

// File: rtl/mm_access_arbiter.sv
// Main-memory line-port arbiter: round-robin ownership among NUM_REQ requesters,
// one read or write per start strobe, with ack timeout and idle-hold limit.
module mm_access_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int LINE_W   = DEF_LINE_W,
    parameter int TIMEOUT  = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                start,
    input  logic [NUM_REQ-1:0]                wr,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr,
    input  logic [NUM_REQ-1:0][LINE_W-1:0]    wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                done,
    output logic [NUM_REQ-1:0]                err,
    output logic [LINE_W-1:0]                 rdata,
    output Taddress                           mm_addr,
    output logic [LINE_W-1:0]                 mm_wdata,
    output logic                              mm_re,
    output logic                              mm_we,
    input  logic                              mm_ack,
    input  logic [LINE_W-1:0]                 mm_rdata
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    Tarb_state            st_r;
    logic [PTR_W-1:0]     owner_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [HOLD_W-1:0]    hold_r;
    logic [TO_W-1:0]      to_r;
    logic                 wr_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [NUM_REQ-1:0]   done_r;
    logic [NUM_REQ-1:0]   err_r;
    logic [LINE_W-1:0]    rdata_r;
    Taddress              mm_addr_r;
    logic [LINE_W-1:0]    mm_wdata_r;
    logic                 mm_re_r;
    logic                 mm_we_r;

    logic [PTR_W-1:0]     nxt_ptr_s;
    logic [PTR_W-1:0]     pick_ptr_s;
    logic [NUM_REQ-1:0]   pick_gnt_s;
    logic [PTR_W-1:0]     pick_idx_s;
    logic                 pick_vld_s;
    logic                 req_own_s;
    logic                 start_own_s;
    logic                 others_req_s;

    // In RELEASE the pointer is already advanced past the old owner, so a
    // waiting requester can be granted straight away (one dead cycle).
    assign nxt_ptr_s    = (owner_r == PTR_W'(NUM_REQ - 1)) ? '0 : owner_r + PTR_W'(1);
    assign pick_ptr_s   = (st_r == RELEASE) ? nxt_ptr_s : ptr_r;
    assign req_own_s    = |(req & gnt_r);
    assign start_own_s  = |(start & gnt_r);
    assign others_req_s = |(req & ~gnt_r);

    mm_access_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req        (req),
        .ptr        (pick_ptr_s),
        .winner     (pick_gnt_s),
        .winner_idx (pick_idx_s),
        .valid      (pick_vld_s)
    );

    // Ownership/access sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r       <= IDLE;
            owner_r    <= '0;
            ptr_r      <= '0;
            hold_r     <= '0;
            to_r       <= '0;
            wr_r       <= 1'b0;
            gnt_r      <= '0;
            done_r     <= '0;
            err_r      <= '0;
            rdata_r    <= '0;
            mm_addr_r  <= '0;
            mm_wdata_r <= '0;
            mm_re_r    <= 1'b0;
            mm_we_r    <= 1'b0;
        end else begin
            done_r <= '0;
            err_r  <= '0;
            case (st_r)
                IDLE: begin
                    if (pick_vld_s) begin
                        gnt_r   <= pick_gnt_s;
                        owner_r <= pick_idx_s;
                        hold_r  <= '0;
                        st_r    <= OWNED;
                    end else begin
                        st_r <= IDLE;
                    end
                end
                OWNED: begin
                    if (!req_own_s) begin
                        gnt_r <= '0;
                        st_r  <= RELEASE;
                    end else if (start_own_s) begin
                        mm_addr_r  <= addr[owner_r];
                        mm_wdata_r <= wdata[owner_r];
                        wr_r       <= wr[owner_r];
                        mm_we_r    <= wr[owner_r];
                        mm_re_r    <= ~wr[owner_r];
                        to_r       <= '0;
                        hold_r     <= '0;
                        st_r       <= ACCESS;
                    end else if (hold_r == HOLD_W'(MAX_HOLD)) begin
                        gnt_r <= '0;
                        st_r  <= RELEASE;
                    end else if (others_req_s) begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end else begin
                        hold_r <= hold_r;
                    end
                end
                ACCESS: begin
                    if (mm_ack) begin
                        mm_re_r <= 1'b0;
                        mm_we_r <= 1'b0;
                        done_r  <= gnt_r;
                        rdata_r <= wr_r ? rdata_r : mm_rdata;
                        if (req_own_s) begin
                            st_r <= OWNED;
                        end else begin
                            gnt_r <= '0;
                            st_r  <= RELEASE;
                        end
                    end else if (to_r == TO_W'(TIMEOUT - 1)) begin
                        mm_re_r <= 1'b0;
                        mm_we_r <= 1'b0;
                        err_r   <= gnt_r;
                        gnt_r   <= '0;
                        st_r    <= RELEASE;
                    end else begin
                        to_r <= to_r + TO_W'(1);
                    end
                end
                RELEASE: begin
                    ptr_r <= nxt_ptr_s;
                    if (pick_vld_s && (pick_idx_s != owner_r)) begin
                        gnt_r   <= pick_gnt_s;
                        owner_r <= pick_idx_s;
                        hold_r  <= '0;
                        st_r    <= OWNED;
                    end else begin
                        st_r <= IDLE;
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    mm_re_r <= 1'b0;
                    mm_we_r <= 1'b0;
                    st_r    <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign done     = done_r;
    assign err      = err_r;
    assign rdata    = rdata_r;
    assign mm_addr  = mm_addr_r;
    assign mm_wdata = mm_wdata_r;
    assign mm_re    = mm_re_r;
    assign mm_we    = mm_we_r;

endmodule

// File: tb/tb_mm_access_arbiter.sv
// Self-checking bench for mm_access_arbiter: cycle table, directed corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_mm_access_arbiter;

    localparam int NR       = 2;
    localparam int LW       = 66;
    localparam int TMO      = 32;
    localparam int MAX_HOLD = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req, start, wr;
    logic [NR-1:0][31:0]  addr;
    logic [NR-1:0][LW-1:0] wdata;
    logic [NR-1:0]        gnt, done, err;
    logic [LW-1:0]        rdata, mm_wdata, mm_rdata;
    logic [31:0]          mm_addr;
    logic                 mm_re, mm_we, mm_ack;

    int checks = 0;
    int errors = 0;

    mm_access_arbiter #(.NUM_REQ(NR), .LINE_W(LW), .TIMEOUT(TMO), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .wr(wr), .addr(addr),
        .wdata(wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_re(mm_re), .mm_we(mm_we),
        .mm_ack(mm_ack), .mm_rdata(mm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [1:0] req, start, wr;
        logic       ack;
        logic [1:0] gnt, done, err;
        logic       re, we;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1; req = '0; start = '0; wr = '0; mm_ack = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    // Reference model: owner / in-flight access / pending release, stepped once per edge.
    int          m_own, m_rel, m_ptr, m_hold, m_cnt;
    bit          m_busy, m_wr;
    logic [1:0]  m_done, m_err;
    logic [LW-1:0] m_rdata, m_wdata;
    logic [31:0] m_addr;

    function automatic int pick(input logic [1:0] r, input int p);
        for (int k = 0; k < NR; k++)
            if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        m_done = '0;
        m_err  = '0;
        if (reset) begin
            m_own = -1; m_rel = -1; m_ptr = 0; m_hold = 0; m_cnt = 0;
            m_busy = 0; m_wr = 0; m_rdata = '0; m_addr = '0; m_wdata = '0;
        end else if (m_rel >= 0) begin
            m_ptr = (m_rel + 1) % NR;
            w = pick(req, m_ptr);
            if (w >= 0 && w != m_rel) begin m_own = w; m_hold = 0; end
            m_rel = -1;
        end else if (m_own < 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin m_own = w; m_hold = 0; end
        end else if (!m_busy) begin
            if (!req[m_own]) begin
                m_rel = m_own; m_own = -1;
            end else if (start[m_own]) begin
                m_busy = 1; m_cnt = 0; m_hold = 0;
                m_wr = wr[m_own]; m_addr = addr[m_own]; m_wdata = wdata[m_own];
            end else if (m_hold == MAX_HOLD) begin
                m_rel = m_own; m_own = -1;
            end else if (req[1 - m_own]) begin
                m_hold++;
            end
        end else begin
            if (mm_ack) begin
                m_done[m_own] = 1'b1;
                if (!m_wr) m_rdata = mm_rdata;
                m_busy = 0;
                if (!req[m_own]) begin m_rel = m_own; m_own = -1; end
            end else if (m_cnt == TMO - 1) begin
                m_err[m_own] = 1'b1;
                m_busy = 0;
                m_rel = m_own; m_own = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        int         first, re_cnt, ack_pct;
        bit         got_err, saw_done;
        logic [1:0] exp_gnt;

        reset = 1'b1; req = '0; start = '0; wr = '0; mm_ack = 1'b0;
        addr[0] = 32'h10; addr[1] = 32'h20;
        wdata[0] = 66'h155; wdata[1] = 66'h2A;
        mm_rdata = 66'h3_FFFF_0000;

        //            rst   req    start  wr     ack   gnt    done   err    re    we
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; req = tbl[i].req; start = tbl[i].start;
            wr = tbl[i].wr; mm_ack = tbl[i].ack;
            cyc();
            chk($sformatf("tbl[%0d]", i), {gnt, done, err, mm_re, mm_we},
                {tbl[i].gnt, tbl[i].done, tbl[i].err, tbl[i].re, tbl[i].we});
            if (i == 0) chk("reset_data", {rdata, mm_addr}, '0);
            if (i == 2) chk("t1_mm_addr", mm_addr, 32'h10);
            if (i == 5) chk("t1_rdata", rdata, 66'h3_FFFF_0000);
        end

        // Owner 1 writes and drops req mid-access.
        reset_dut();
        req = 2'b10; cyc();
        chk("t3_gnt", gnt, 2'b10);
        start = 2'b10; wr = 2'b10; cyc(); start = '0;
        chk("t3_cmd", {mm_re, mm_we}, 2'b01);
        chk("t3_wline", {mm_addr, mm_wdata}, {32'h20, 66'h2A});
        req = 2'b00; cyc();
        chk("t3_hold1", {gnt, mm_we}, {2'b10, 1'b1});
        cyc();
        chk("t3_hold2", {gnt, mm_we}, {2'b10, 1'b1});
        mm_ack = 1'b1; cyc(); mm_ack = 1'b0;
        chk("t3_done", {gnt, done, mm_we}, {2'b00, 2'b10, 1'b0});
        chk("t3_rdata_kept", rdata, 66'h0);
        cyc();
        chk("t3_after", {gnt, done}, 4'b0000);

        // Idle owner forced off by the hold limit.
        reset_dut();
        req = 2'b11; cyc();
        chk("t4_gnt0", gnt, 2'b01);
        first = 0;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (gnt == 2'b10 && first == 0) first = c;
        end
        chk("t4_release_cycle", first, 18);

        // Timeout without ack.
        reset_dut();
        req = 2'b01; cyc();
        start = 2'b01; wr = 2'b00; cyc(); start = '0;
        re_cnt = 0; got_err = 0; saw_done = 0;
        for (int c = 0; c < 50 && !got_err; c++) begin
            if (mm_re) re_cnt++;
            if (done != 2'b00) saw_done = 1;
            if (err != 2'b00) begin
                got_err = 1;
                chk("t5_abort", {gnt, err, mm_re}, {2'b00, 2'b01, 1'b0});
            end
            cyc();
        end
        chk("t5_err_seen", got_err, 1'b1);
        chk("t5_re_cycles", re_cnt, TMO);
        chk("t5_no_done", saw_done, 1'b0);

        // Reset mid-access, then a stray start from a non-owner.
        reset_dut();
        req = 2'b01; cyc();
        start = 2'b01; wr = 2'b00; cyc(); start = '0;
        chk("t6_in_access", mm_re, 1'b1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("t6_rst_ctl", {gnt, done, err, mm_re, mm_we, mm_addr}, '0);
        chk("t6_rst_data", {rdata, mm_wdata}, '0);
        cyc();
        chk("t6_regrant", gnt, 2'b01);
        start = 2'b10; wr = 2'b10; cyc(); start = '0;
        chk("t6_stray", {mm_re, mm_we, gnt, done}, {1'b0, 1'b0, 2'b01, 2'b00});
        cyc();
        chk("t6_stray2", {mm_re, mm_we, done}, 4'b0000);

        // Randomized traffic against the reference model.
        req = '0;
        for (int n = 0; n < 3000; n++) begin
            reset = (n == 0) || ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
                start[i] = ($urandom_range(0, 3) == 0);
                wr[i]    = 1'($urandom);
                addr[i]  = $urandom;
                wdata[i] = {2'($urandom), $urandom, $urandom};
            end
            ack_pct  = (((n / 250) % 2) == 1) ? 1 : 35;
            mm_ack   = ($urandom_range(0, 99) < ack_pct);
            mm_rdata = {2'($urandom), $urandom, $urandom};
            model_step();
            cyc();
            exp_gnt = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
            chk("rand_ctl", {gnt, done, err, mm_re, mm_we},
                {exp_gnt, m_done, m_err, m_busy && !m_wr, m_busy && m_wr});
            chk("rand_rdata", rdata, m_rdata);
            if (m_busy) chk("rand_mm_line", {mm_addr, mm_wdata}, {m_addr, m_wdata});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
